// File: rtl/arb_defs.sv
`default_nettype none
// ============================================================================
// Module   : arb_defs
// Brief    : Shared constants and state encodings for the round-robin arbiter.
// Revision : 1.0
// ============================================================================
package arb_defs;

    localparam int         N_REQ    = 4;
    localparam int         IDX_W    = 2;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dec2to4.sv
`default_nettype none
// ============================================================================
// Module   : dec2to4
// Brief    : 2-to-4 one-hot decoder with enable; all-zero output when disabled.
// Revision : 1.0
// ============================================================================
module dec2to4 (
    input  logic       enable,
    input  logic [1:0] I,
    output logic [3:0] Z
);

    assign Z = enable ? (4'b0001 << I) : 4'b0000;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Brief    : Four-requester round-robin arbiter with bounded grant hold time.
// Revision : 1.0
// ============================================================================
module rr_arbiter4
    import arb_defs::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_en,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nxt;
    logic [IDX_W-1:0] rel_ptr;
    logic             release_now;

    // Rotate so the pointer lands at bit 0, take the lowest set bit, then undo the rotation.
    function automatic logic [IDX_W-1:0] pick_winner(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] p
    );
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        dbl = {r, r};
        rot = dbl[p +: N_REQ];
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        return p + off;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            gnt_idx <= idx_nxt;
        end
    end

    assign release_now = !req[gnt_idx] || (cnt >= 8'(MAX_HOLD));
    assign rel_ptr     = gnt_idx + 1'b1;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        idx_nxt   = gnt_idx;
        case (state)
            ST_IDLE: begin
                if (req != '0) begin
                    idx_nxt   = pick_winner(req, ptr);
                    cnt_nxt   = 8'd1;
                    state_nxt = ST_GRANT;
                end
            end
            default: begin
                if (release_now) begin
                    // Re-arbitrate on the same edge from the advanced pointer.
                    ptr_nxt = rel_ptr;
                    if (req != '0) begin
                        idx_nxt   = pick_winner(req, rel_ptr);
                        cnt_nxt   = 8'd1;
                        state_nxt = ST_GRANT;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        gnt_en = (state == ST_GRANT);
        busy   = (state == ST_GRANT);
    end

    dec2to4 u_dec (
        .enable (gnt_en),
        .I      (gnt_idx),
        .Z      (gnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Brief    : Directed self-checking bench for rr_arbiter4 (MAX_HOLD 8 and 2).
// Revision : 1.0
// ============================================================================
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [1:0] idx8, idx2;
    logic       en8, en2, busy8, busy2;
    logic [3:0] gnt8, gnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt_idx (idx8),
        .gnt_en  (en8),
        .gnt     (gnt8),
        .busy    (busy8)
    );

    rr_arbiter4 #(.MAX_HOLD(2)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt_idx (idx2),
        .gnt_en  (en2),
        .gnt     (gnt2),
        .busy    (busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] rot_exp [9];
        rot_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                    4'b0100, 4'b1000, 4'b1000, 4'b0001};

        // Reset held with all requests asserted
        reset = 1'b1; req = 4'b1111;
        tick();
        tick();
        check("rst_gnt8",  32'(gnt8),  32'h0);
        check("rst_busy8", 32'(busy8), 32'h0);
        check("rst_en8",   32'(en8),   32'h0);
        check("rst_idx8",  32'(idx8),  32'h0);
        check("rst_gnt2",  32'(gnt2),  32'h0);
        reset = 1'b0;
        tick();
        check("first_gnt", 32'(gnt8), 32'h1);
        check("first_busy", 32'(busy8), 32'h1);

        // Single requester, then pointer must have advanced to 3
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0; req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("single_%0d", i), 32'(gnt8), 32'h4);
        end
        req = 4'b0000;
        tick();
        check("single_off", 32'(gnt8), 32'h0);
        check("single_off_busy", 32'(busy8), 32'h0);
        req = 4'b1111;
        tick();
        check("ptr_after_single", 32'(gnt8), 32'h8);
        check("ptr_after_single_idx", 32'(idx8), 32'h3);

        // Fair rotation with MAX_HOLD=2
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0; req = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rot_%0d", i), 32'(gnt2), 32'(rot_exp[i]));
        end

        // Early release hand-off, plus dropping a non-granted request
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0; req = 4'b0011;
        tick();
        check("handoff_a", 32'(gnt8), 32'h1);
        req = 4'b0001;
        tick();
        check("nongrant_drop", 32'(gnt8), 32'h1);
        req = 4'b0010;
        tick();
        check("handoff_b", 32'(gnt8), 32'h2);
        check("handoff_busy", 32'(busy8), 32'h1);

        // Lone holder across several timeouts
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0; req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("lone_%0d", i), 32'(gnt8), 32'h8);
        end
        check("lone_idx2", 32'(gnt2), 32'h8);

        // Reset mid-grant restarts from requester 0
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0; req = 4'b0100;
        tick();
        check("mid_pre", 32'(gnt8), 32'h4);
        reset = 1'b1; req = 4'b1111;
        tick();
        check("mid_rst", 32'(gnt8), 32'h0);
        check("mid_rst_busy", 32'(busy8), 32'h0);
        reset = 1'b0;
        tick();
        check("mid_restart", 32'(gnt8), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
